// File: rtl/rv32i_pkg.sv
// RV32I encoder shared definitions: mnemonic codes, opcodes,
// funct fields, error codes and small field-lookup helpers.
package rv32i_pkg;

    typedef enum logic [5:0] {
        MN_LUI = 6'd0, MN_AUIPC, MN_JAL, MN_JALR,
        MN_BEQ, MN_BNE, MN_BLT, MN_BGE, MN_BLTU, MN_BGEU,
        MN_LB, MN_LH, MN_LW, MN_LBU, MN_LHU,
        MN_SB, MN_SH, MN_SW,
        MN_ADDI, MN_SLTI, MN_SLTIU, MN_XORI, MN_ORI, MN_ANDI,
        MN_SLLI, MN_SRLI, MN_SRAI,
        MN_ADD, MN_SUB, MN_SLL, MN_SLT, MN_SLTU,
        MN_XOR, MN_SRL, MN_SRA, MN_OR, MN_AND
    } mnem_e;

    localparam logic [5:0] NUM_MNEM = 6'd37;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;
    localparam logic [1:0] ERR_MISALIGN = 2'd3;

    function automatic logic [2:0] funct3_of(input logic [5:0] m);
        logic [2:0] f;
        f = 3'd0;
        case (m)
            MN_BEQ:   f = F3_BEQ;
            MN_BNE:   f = F3_BNE;
            MN_BLT:   f = F3_BLT;
            MN_BGE:   f = F3_BGE;
            MN_BLTU:  f = F3_BLTU;
            MN_BGEU:  f = F3_BGEU;
            MN_LB, MN_SB:  f = F3_B;
            MN_LH, MN_SH:  f = F3_H;
            MN_LW, MN_SW:  f = F3_W;
            MN_LBU:   f = F3_BU;
            MN_LHU:   f = F3_HU;
            MN_SLTI, MN_SLT:   f = F3_SLT;
            MN_SLTIU, MN_SLTU: f = F3_SLTU;
            MN_XORI, MN_XOR:   f = F3_XOR;
            MN_ORI, MN_OR:     f = F3_OR;
            MN_ANDI, MN_AND:   f = F3_AND;
            MN_SLLI, MN_SLL:   f = F3_SLL;
            MN_SRLI, MN_SRAI, MN_SRL, MN_SRA: f = F3_SR;
            default:  f = F3_ADD;
        endcase
        return f;
    endfunction

    function automatic logic [6:0] funct7_of(input logic [5:0] m);
        return (m == MN_SUB || m == MN_SRA || m == MN_SRAI)
            ? F7_ALT : F7_BASE;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Small synchronous FIFO holding {addr, inst} pairs.
// The head reads as zero whenever the FIFO is empty.
module inst_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + 1'b1;
            if (pop)  r_rptr <= r_rptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wptr] <= wdata;
    end

    assign rdata = (r_count != '0) ? r_mem[r_rptr] : '0;
    assign count = r_count;

endmodule

// File: rtl/rv32i_inst_encoder.sv
// RV32I instruction encoder with field checking, an address
// counter and a small output FIFO for the program-load path.
module rv32i_inst_encoder
    import rv32i_pkg::*;
#(
    parameter int                 DEPTH     = 2,
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        mnem,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [7:0]        err_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic signed [31:0] w_simm;
    logic               w_fit12;
    logic               w_fit_sh;
    logic               w_fit_b;
    logic               w_fit_j;
    logic [2:0]         w_f3;
    logic [6:0]         w_f7;
    logic [31:0]        w_inst;
    logic               w_illegal;
    logic               w_misal;
    logic               w_range;
    logic [1:0]         w_err;
    logic               w_accept;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic [CW-1:0]      w_count;
    logic [ADDR_W+31:0] w_head;

    logic [ADDR_W-1:0]  r_addr;
    logic               r_err_valid;
    logic [1:0]         r_err_code;
    logic [7:0]         r_err_count;

    assign w_simm   = $signed(imm);
    assign w_fit12  = (w_simm >= -32'sd2048) && (w_simm <= 32'sd2047);
    assign w_fit_sh = (imm < 32'd32);
    assign w_fit_b  = (w_simm >= -32'sd4096) && (w_simm <= 32'sd4094);
    assign w_fit_j  = (w_simm >= -32'sd1048576)
                   && (w_simm <= 32'sd1048574);
    assign w_f3     = funct3_of(mnem);
    assign w_f7     = funct7_of(mnem);

    always_comb begin
        w_inst    = '0;
        w_illegal = 1'b0;
        w_misal   = 1'b0;
        w_range   = 1'b0;
        case (mnem)
            MN_LUI, MN_AUIPC: begin
                w_inst  = {imm[31:12], rd,
                           (mnem == MN_LUI) ? OP_LUI : OP_AUIPC};
                w_range = |imm[11:0];
            end
            MN_JAL: begin
                w_inst  = {imm[20], imm[10:1], imm[11],
                           imm[19:12], rd, OP_JAL};
                w_misal = imm[0];
                w_range = !w_fit_j;
            end
            MN_JALR: begin
                w_inst  = {imm[11:0], rs1, 3'd0, rd, OP_JALR};
                w_range = !w_fit12;
            end
            MN_BEQ, MN_BNE, MN_BLT, MN_BGE, MN_BLTU, MN_BGEU: begin
                w_inst  = {imm[12], imm[10:5], rs2, rs1, w_f3,
                           imm[4:1], imm[11], OP_BRANCH};
                w_misal = imm[0];
                w_range = !w_fit_b;
            end
            MN_LB, MN_LH, MN_LW, MN_LBU, MN_LHU: begin
                w_inst  = {imm[11:0], rs1, w_f3, rd, OP_LOAD};
                w_range = !w_fit12;
            end
            MN_SB, MN_SH, MN_SW: begin
                w_inst  = {imm[11:5], rs2, rs1, w_f3,
                           imm[4:0], OP_STORE};
                w_range = !w_fit12;
            end
            MN_ADDI, MN_SLTI, MN_SLTIU,
            MN_XORI, MN_ORI, MN_ANDI: begin
                w_inst  = {imm[11:0], rs1, w_f3, rd, OP_IMM};
                w_range = !w_fit12;
            end
            MN_SLLI, MN_SRLI, MN_SRAI: begin
                w_inst  = {w_f7, imm[4:0], rs1, w_f3, rd, OP_IMM};
                w_range = !w_fit_sh;
            end
            MN_ADD, MN_SUB, MN_SLL, MN_SLT, MN_SLTU,
            MN_XOR, MN_SRL, MN_SRA, MN_OR, MN_AND: begin
                w_inst = {w_f7, rs2, rs1, w_f3, rd, OP_REG};
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Illegal beats misaligned beats out-of-range.
    assign w_err = w_illegal ? ERR_ILLEGAL
                 : w_misal   ? ERR_MISALIGN
                 : w_range   ? ERR_RANGE
                 : ERR_NONE;

    assign in_ready  = (w_count < CW'(DEPTH)) && !restart;
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && (w_err == ERR_NONE);
    assign w_drop    = w_accept && (w_err != ERR_NONE);
    assign out_valid = (w_count != '0);
    assign w_pop     = out_valid && out_ready;

    inst_fifo #(
        .DEPTH (DEPTH),
        .W     (ADDR_W + 32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (restart),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({r_addr, w_inst}),
        .rdata (w_head),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            r_addr      <= BASE_ADDR;
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_count <= '0;
        end else begin
            r_err_valid <= w_drop;
            if (w_push) r_addr <= r_addr + ADDR_W'(4);
            if (w_drop) begin
                r_err_code <= w_err;
                if (r_err_count != 8'hFF)
                    r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign out_inst  = w_head[31:0];
    assign out_addr  = w_head[ADDR_W+31:32];
    assign err_valid = r_err_valid;
    assign err_code  = r_err_code;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Directed bench for rv32i_inst_encoder: encodings, FIFO
// back-pressure, error reporting, restart and reset.
module tb_rv32i_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        restart;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  mnem;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv32i_inst_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (restart),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mnem      (mnem),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .err_valid (err_valid),
        .err_code  (err_code),
        .err_count (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [5:0] m, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2,
                           input logic [31:0] im);
        mnem = m;
        rd   = d;
        rs1  = s1;
        rs2  = s2;
        imm  = im;
    endtask

    task automatic send(input logic [5:0] m, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] im);
        set_req(m, d, s1, s2, im);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] inst,
                            input logic [31:0] addr);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_inst"}, out_inst, inst);
        chk({tag, "_addr"}, out_addr, addr);
    endtask

    initial begin
        rst_n     = 1'b0;
        restart   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_req(6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_err_valid", 32'(err_valid), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // ADDI x1, x0, 5
        send(6'd18, 5'd1, 5'd0, 5'd0, 32'd5);
        chk_head("addi", 32'h00500093, 32'h0);
        tick();
        chk("addi_drained", 32'(out_valid), 32'd0);

        // SUB then BEQ, back to back
        do_restart();
        send(6'd28, 5'd3, 5'd1, 5'd2, 32'd0);
        chk_head("sub", 32'h402081B3, 32'h0);
        send(6'd4, 5'd0, 5'd1, 5'd2, -32'sd4);
        chk_head("beq", 32'hFE208EE3, 32'h4);
        tick();
        chk("beq_drained", 32'(out_valid), 32'd0);

        // Back-pressure: third request stalls while FIFO full
        do_restart();
        out_ready = 1'b0;
        send(6'd18, 5'd1, 5'd0, 5'd0, 32'd1);
        send(6'd18, 5'd2, 5'd0, 5'd0, 32'd2);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        set_req(6'd18, 5'd3, 5'd0, 5'd0, 32'd3);
        in_valid = 1'b1;
        tick();
        chk("full_in_ready2", 32'(in_ready), 32'd0);
        chk_head("hold", 32'h00100093, 32'h0);
        out_ready = 1'b1;
        tick();
        chk_head("drain1", 32'h00200113, 32'h4);
        chk("drain1_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk_head("drain2", 32'h00300193, 32'h8);
        tick();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Error reporting
        do_restart();
        send(6'd40, 5'd1, 5'd1, 5'd1, 32'd0);
        chk("ill_err_valid", 32'(err_valid), 32'd1);
        chk("ill_err_code", 32'(err_code), 32'd1);
        chk("ill_out_valid", 32'(out_valid), 32'd0);
        send(6'd18, 5'd1, 5'd0, 5'd0, 32'd2048);
        chk("rng_err_code", 32'(err_code), 32'd2);
        send(6'd2, 5'd1, 5'd0, 5'd0, 32'd3);
        chk("mis_err_code", 32'(err_code), 32'd3);
        chk("mis_err_valid", 32'(err_valid), 32'd1);
        tick();
        chk("err_pulse_end", 32'(err_valid), 32'd0);
        chk("err_count3", 32'(err_count), 32'd3);
        chk("err_code_hold", 32'(err_code), 32'd3);
        chk("err_no_out", 32'(out_valid), 32'd0);

        // Legal words after errors start at address 0
        send(6'd18, 5'd1, 5'd0, 5'd0, 32'd5);
        chk_head("post_err", 32'h00500093, 32'h0);
        send(6'd18, 5'd1, 5'd0, 5'd0, -32'sd2048);
        chk_head("addi_min", 32'h80000093, 32'h4);
        send(6'd26, 5'd1, 5'd1, 5'd0, 32'd31);
        chk_head("srai31", 32'h41F0D093, 32'h8);
        send(6'd2, 5'd1, 5'd0, 5'd0, 32'd2048);
        chk_head("jal", 32'h001000EF, 32'hC);
        send(6'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        chk_head("lui", 32'h123452B7, 32'h10);
        send(6'd17, 5'd0, 5'd2, 5'd3, 32'd8);
        chk_head("sw", 32'h00312423, 32'h14);
        tick();

        // More illegal fields
        send(6'd24, 5'd1, 5'd1, 5'd0, 32'd32);
        chk("slli32_code", 32'(err_code), 32'd2);
        send(6'd4, 5'd0, 5'd1, 5'd2, 32'd4095);
        chk("b_odd_code", 32'(err_code), 32'd3);
        send(6'd0, 5'd1, 5'd0, 5'd0, 32'h12345001);
        chk("lui_low_err", 32'(err_valid), 32'd1);
        chk("err_count6", 32'(err_count), 32'd6);
        tick();
        chk("err_no_out2", 32'(out_valid), 32'd0);

        // Error count saturation
        do_restart();
        chk("rs_err_count", 32'(err_count), 32'd0);
        set_req(6'd63, 5'd0, 5'd0, 5'd0, 32'd0);
        in_valid = 1'b1;
        repeat (255) @(posedge clk);
        #1;
        chk("sat_255", 32'(err_count), 32'd255);
        tick();
        tick();
        in_valid = 1'b0;
        chk("sat_hold", 32'(err_count), 32'd255);
        chk("sat_err_valid", 32'(err_valid), 32'd1);

        // Restart with buffered words
        do_restart();
        chk("rs2_err_count", 32'(err_count), 32'd0);
        chk("rs2_err_code", 32'(err_code), 32'd0);
        out_ready = 1'b0;
        send(6'd18, 5'd1, 5'd0, 5'd0, 32'd1);
        send(6'd40, 5'd0, 5'd0, 5'd0, 32'd0);
        send(6'd18, 5'd2, 5'd0, 5'd0, 32'd2);
        chk("buf_err_count", 32'(err_count), 32'd1);
        chk_head("buf", 32'h00100093, 32'h0);
        set_req(6'd18, 5'd3, 5'd0, 5'd0, 32'd3);
        in_valid = 1'b1;
        restart  = 1'b1;
        #1;
        chk("rs_in_ready", 32'(in_ready), 32'd0);
        tick();
        restart  = 1'b0;
        in_valid = 1'b0;
        chk("rs_out_valid", 32'(out_valid), 32'd0);
        chk("rs_err_count2", 32'(err_count), 32'd0);
        chk("rs_err_code2", 32'(err_code), 32'd0);
        out_ready = 1'b1;
        send(6'd18, 5'd1, 5'd0, 5'd0, 32'd5);
        chk_head("post_rs", 32'h00500093, 32'h0);
        tick();

        // Reset mid-stream
        out_ready = 1'b0;
        send(6'd18, 5'd1, 5'd0, 5'd0, 32'd1);
        send(6'd40, 5'd0, 5'd0, 5'd0, 32'd0);
        send(6'd18, 5'd2, 5'd0, 5'd0, 32'd2);
        rst_n = 1'b0;
        tick();
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_out_inst", out_inst, 32'd0);
        chk("mrst_out_addr", out_addr, 32'd0);
        chk("mrst_err_valid", 32'(err_valid), 32'd0);
        chk("mrst_err_code", 32'(err_code), 32'd0);
        chk("mrst_err_count", 32'(err_count), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(6'd18, 5'd1, 5'd0, 5'd0, 32'd5);
        chk_head("post_rst", 32'h00500093, 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
